opal_kelly_burst_ctrl: RTL

Consumes the one-bit start level driven by the Opal Kelly control PIO and turns each rising edge into one burst of BURST_LEN words. Words are moved from a show-ahead FIFO onto a valid/ready transmit interface toward the Opal Kelly bridge. Sits directly downstream of the control PIO's out_port and upstream of the host-link transmitter. Reports busy, per-burst completion and word progress back for status readback.

---
 rtl/opal_kelly_burst_ctrl_if.sv | 22 ++
 rtl/opal_kelly_burst_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/opal_kelly_burst_ctrl_if.sv
// FIFO read side and valid/ready transmit side of opal_kelly_burst_ctrl.
// The master modport is the controller's view; the slave modport is the FIFO/sink side.
interface opal_kelly_burst_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_rdreq;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  fifo_empty, fifo_rdata, tx_ready,
    output fifo_rdreq, tx_data, tx_valid
  );

  modport slave (
    output fifo_empty, fifo_rdata, tx_ready,
    input  fifo_rdreq, tx_data, tx_valid
  );
endinterface

// File: rtl/opal_kelly_burst_ctrl.sv
// Turns each rising edge of the control-PIO start level into one burst of BURST_LEN FIFO words.
// Optional stall abort is enabled by defining OK_TIMEOUT_EN.
module opal_kelly_burst_ctrl #(
  parameter int DATA_W         = 32,
  parameter int BURST_LEN      = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          trigger_in,
  opal_kelly_burst_ctrl_if.master       bus,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout,
  output logic [15:0]                   words_sent
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [15:0] LAST_CNT = 16'(BURST_LEN - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
    end
    if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_bad_len
      $error("BURST_LEN must be within 1..65535");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..65535");
    end
  endgenerate

  logic [1:0]             state_reg;
  logic [SYNC_STAGES-1:0] sync_chain_reg;
  logic                   sync_d_reg;
  logic                   sync;
  logic                   rise;
  logic [DATA_W-1:0]      tx_data_reg;
  logic                   tx_valid_reg;
  logic [15:0]            words_sent_reg;
  logic                   accept;
  logic                   last_word;
  logic                   rdreq;
  logic                   stall_abort;

  // Trigger synchronizer; sync_chain_reg[0] is the first flop to see trigger_in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain_reg <= '0;
      sync_d_reg     <= 1'b0;
    end else begin
      sync_chain_reg <= {sync_chain_reg[SYNC_STAGES-2:0], trigger_in};
      sync_d_reg     <= sync;
    end
  end

  assign sync = sync_chain_reg[SYNC_STAGES-1];
  assign rise = sync & ~sync_d_reg;

  always_comb begin
    accept    = tx_valid_reg & bus.tx_ready;
    last_word = (words_sent_reg == LAST_CNT);
    rdreq     = 1'b0;
    case (state_reg)
      FETCH:   rdreq = ~bus.fifo_empty;
      SEND:    rdreq = accept & ~last_word & ~bus.fifo_empty & ~stall_abort;
      default: rdreq = 1'b0;
    endcase
  end

`ifdef OK_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] stall_cnt_reg;
  logic        timeout_reg;
  logic        stalled;

  assign stalled     = tx_valid_reg & ~bus.tx_ready;
  assign stall_abort = stalled & (stall_cnt_reg == TIMEOUT_LAST);

  // Counts consecutive stalled edges; the abort edge itself is the TIMEOUT_CYCLES-th.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_reg <= 16'd0;
      timeout_reg   <= 1'b0;
    end else begin
      timeout_reg <= stall_abort;
      if (!stalled || stall_abort) begin
        stall_cnt_reg <= 16'd0;
      end else begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

  assign timeout = timeout_reg;
`else
  assign stall_abort = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      tx_data_reg    <= '0;
      tx_valid_reg   <= 1'b0;
      words_sent_reg <= 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rise) begin
            words_sent_reg <= 16'd0;
            state_reg      <= FETCH;
          end
        end
        FETCH: begin
          if (!bus.fifo_empty) begin
            tx_data_reg  <= bus.fifo_rdata;
            tx_valid_reg <= 1'b1;
            state_reg    <= SEND;
          end
        end
        SEND: begin
          if (stall_abort) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end else if (accept) begin
            words_sent_reg <= words_sent_reg + 16'd1;
            if (last_word) begin
              tx_valid_reg <= 1'b0;
              state_reg    <= DONE;
            end else if (!bus.fifo_empty) begin
              // Back-to-back: next head word replaces the accepted one with no bubble.
              tx_data_reg <= bus.fifo_rdata;
            end else begin
              tx_valid_reg <= 1'b0;
              state_reg    <= FETCH;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_rdreq = rdreq;
  assign bus.tx_data    = tx_data_reg;
  assign bus.tx_valid   = tx_valid_reg;
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);
  assign words_sent     = words_sent_reg;

endmodule
